// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, waits the memory read latency, presents
// fetched words to decode over valid/ready, resolves local 'br' and execute redirects.
module instr_fetch_unit #(
  parameter int unsigned RD_WAIT   = 2,
  parameter int unsigned MEM_BYTES = 40,
  parameter logic [4:0]  OP_BR     = 5'b00011
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        br_taken,
  output logic        halted
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam int unsigned CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(RD_WAIT - 1);
  localparam logic [31:0]   LIMIT    = 32'(MEM_BYTES);

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [CW-1:0] wait_cnt;

  logic [31:0] redir_target;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] seq_target;
  logic        is_br;

  // The memory sees the registered PC directly, so the address only moves when pc does.
  assign imem_addr = pc;

  assign redir_target = redirect_pc & 32'hFFFF_FFFC;
  assign br_offset    = {{3{imem_instr[26]}}, imem_instr[26:0], 2'b00};
  assign br_target    = pc + 32'd4 + br_offset;
  assign seq_target   = pc + 32'd4;
  assign is_br        = (imem_instr[31:27] == OP_BR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      pc        <= '0;
      wait_cnt  <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      br_taken  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      br_taken <= 1'b0;
      if (redirect_valid) begin
        // Redirect outranks everything, including a br sampled this very cycle.
        pc        <= redir_target;
        out_valid <= 1'b0;
        wait_cnt  <= '0;
        if (redir_target >= LIMIT) begin
          state  <= HALT;
          halted <= 1'b1;
        end else begin
          state  <= FETCH;
          halted <= 1'b0;
        end
      end else begin
        case (state)
          FETCH: begin
            if (wait_cnt == LAST_CNT) begin
              wait_cnt <= '0;
              if (is_br) begin
                pc       <= br_target;
                br_taken <= 1'b1;
                if (br_target >= LIMIT) begin
                  state  <= HALT;
                  halted <= 1'b1;
                end
              end else begin
                out_instr <= imem_instr;
                out_pc    <= pc;
                out_valid <= 1'b1;
                state     <= HOLD;
              end
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              pc        <= seq_target;
              if (seq_target >= LIMIT) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end
          end
          HALT: begin
            out_valid <= 1'b0;
          end
          default: begin
            state     <= FETCH;
            out_valid <= 1'b0;
            wait_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected fetches are queued by the stimulus
// and compared by a negedge monitor on every accepted handshake.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        br_taken;
  logic        halted;

  logic [31:0] rom [0:15];
  fetch_t      exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          br_seen = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RD_WAIT(2), .MEM_BYTES(40), .OP_BR(5'b00011)) u_dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_taken(br_taken), .halted(halted)
  );

  // Word-addressed program memory; reads outside the program space return 0.
  assign imem_instr = (imem_addr < 32'd40) ? rom[imem_addr[5:2]] : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    fetch_t f;
    f.pc = pc;
    f.instr = instr;
    exp_q.push_back(f);
  endtask

  task automatic wait_valid(input string name, input int exp_n);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  // Monitor: every accepted instruction must match the head of the expected queue.
  always @(negedge clk) begin
    if (br_taken) br_seen++;
    if (reset_n && out_valid && out_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_unexpected: got pc 0x%08h, expected nothing", out_pc);
      end else begin
        fetch_t e;
        e = exp_q.pop_front();
        check("accept_pc", out_pc, e.pc);
        check("accept_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rom[0] = 32'h5800000F;  rom[1] = 32'h58080010;  rom[2] = 32'h18000001;
    rom[3] = 32'h10009000;  rom[4] = 32'h08000002;  rom[5] = 32'h20000014;
    rom[6] = 32'h20000018;  rom[7] = 32'h2000001C;  rom[8] = 32'h20000020;
    rom[9] = 32'h20000024;

    reset_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_flags", {30'd0, br_taken, halted}, 32'd0);

    // Sequential fetch: first word 2 cycles after release, next 3 cycles later.
    out_ready = 1'b1;
    push(32'd0, 32'h5800000F);
    reset_n = 1'b1;
    wait_valid("lat_pc0", 2);
    push(32'd4, 32'h58080010);
    tick();
    check("accept_drops_valid", 32'(out_valid), 32'd0);
    check("addr_after_accept", imem_addr, 32'd4);
    wait_valid("lat_pc4", 2);

    // Local br at pc 8 jumps to 16; neither 8 nor 12 reaches decode.
    push(32'd16, 32'h08000002);
    tick();
    check("addr_pc8", imem_addr, 32'd8);
    tick();
    tick();
    check("br_pulse_hi", 32'(br_taken), 32'd1);
    check("br_target_addr", imem_addr, 32'd16);
    check("br_not_presented", 32'(out_valid), 32'd0);
    tick();
    check("br_pulse_lo", 32'(br_taken), 32'd0);
    wait_valid("lat_after_br", 1);

    // Back-pressure: held instruction stays put.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_pc", out_pc, 32'd16);
      check("hold_instr", out_instr, 32'h08000002);
      check("hold_addr", imem_addr, 32'd16);
    end
    out_ready = 1'b1;
    tick();
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_addr", imem_addr, 32'd20);
    push(32'd20, 32'h20000014);
    wait_valid("lat_pc20", 2);
    tick();

    // Redirect during the FETCH wait: aligned target, counter restarts.
    redirect_valid = 1'b1; redirect_pc = 32'h0000000E;
    tick();
    redirect_valid = 1'b0;
    check("redir_addr", imem_addr, 32'd12);
    push(32'd12, 32'h10009000);
    tick();
    check("redir_cnt_restart", 32'(out_valid), 32'd0);
    wait_valid("redir_lat", 1);
    tick();

    // Redirect in HOLD together with out_ready: held word dropped.
    wait_valid("lat_pc16", 2);
    check("pre_redir_pc", out_pc, 32'd16);
    redirect_valid = 1'b1; redirect_pc = 32'd4;
    tick();
    redirect_valid = 1'b0;
    check("redir_hold_valid", 32'(out_valid), 32'd0);
    check("redir_hold_addr", imem_addr, 32'd4);
    push(32'd4, 32'h58080010);
    wait_valid("lat_redir4", 2);
    tick();

    // Run to the end of program space.
    redirect_valid = 1'b1; redirect_pc = 32'd32;
    tick();
    redirect_valid = 1'b0;
    push(32'd32, 32'h20000020);
    push(32'd36, 32'h20000024);
    wait_valid("lat_pc32", 2);
    tick();
    wait_valid("lat_pc36", 2);
    tick();
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_addr", imem_addr, 32'd40);
    for (int i = 0; i < 22; i++) begin
      tick();
      check("halt_idle", {30'd0, halted, out_valid}, 32'd2);
    end

    redirect_valid = 1'b1; redirect_pc = 32'h00000100;
    tick();
    redirect_valid = 1'b0;
    check("redir_oob_halt", 32'(halted), 32'd1);
    check("redir_oob_addr", imem_addr, 32'h100);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    check("unhalt", 32'(halted), 32'd0);
    wait_valid("lat_unhalt", 2);
    check("unhalt_pc", out_pc, 32'd0);
    check("unhalt_instr", out_instr, 32'h5800000F);
    repeat (3) tick();
    check("hold0_valid", 32'(out_valid), 32'd1);

    // Asynchronous reset between clock edges while holding.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_pc", out_pc, 32'd0);
    check("async_rst_addr", imem_addr, 32'd0);
    tick();
    tick();
    out_ready = 1'b1;
    push(32'd0, 32'h5800000F);
    reset_n = 1'b1;
    wait_valid("lat_after_reset", 2);
    tick();
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("br_pulse_count", 32'(br_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
